// File: rtl/spi_req_scheduler_pkg.sv
// Shared definitions for the SPI request scheduler.
//   state_t      : scheduler FSM states
//   SS_IDLE      : all-ones "no slave selected" code (sliced to SSW by users)
//   TOUT_DEFAULT : default number of cycles allowed for spi_done to arrive
package spi_req_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_START,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam int SS_MAXW = 8;
  localparam logic [SS_MAXW-1:0] SS_IDLE = '1;

  localparam int TOUT_DEFAULT = 255;

endpackage

// File: rtl/spi_req_scheduler_rr_arbiter.sv
// Combinational round-robin pick.
//   req   : request vector
//   ptr   : index that has highest priority this round
//   gnt   : one-hot grant of the winner (all zero when no request)
//   idx   : index of the winner
//   found : at least one request is set
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            found
);

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  int                pos;

  // Rotate so that bit 0 of req_rot is requester ptr; doubling gives wrap-around.
  assign req_dbl = {req, req};
  assign req_rot = NREQ'(req_dbl >> ptr);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    gnt   = '0;
    pos   = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        pos   = int'(ptr) + i;
        if (pos >= NREQ) pos = pos - NREQ;
      end
    end
    if (found) begin
      idx = IDW'(pos);
      gnt = NREQ'(1) << pos;
    end
  end

endmodule

// File: rtl/spi_req_scheduler.sv
// Shares one SPI master between NREQ requesters by round-robin.
// A granted requester gets its slave select and command byte driven, a single
// en_spi start pulse, and then either its received byte (rsp_valid) or a
// timeout indication (tout_err) if spi_done never rises.
//   clk, rst          : clock, asynchronous active-high reset
//   req/req_cmd/req_ss: per-requester level request, command byte, slave code
//   spi_done/spi_rx   : SPI master completion level and received byte
//   en_spi/spi_tx/SS  : start pulse, command byte and slave select to SPI
//   gnt/busy          : one-hot grant held per transaction, FSM not idle
//   rsp_valid/rsp_id/rsp_data/tout_err : completion report to requesters
module spi_req_scheduler
  import spi_req_scheduler_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int DATABITS = 8,
  parameter int SSW      = 2,
  parameter int TOUT     = TOUT_DEFAULT,
  parameter int IDW      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATABITS-1:0] req_cmd,
  input  logic [NREQ*SSW-1:0]      req_ss,
  input  logic                     spi_done,
  input  logic [DATABITS-1:0]      spi_rx,
  output logic                     en_spi,
  output logic [DATABITS-1:0]      spi_tx,
  output logic [SSW-1:0]           SS,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [DATABITS-1:0]      rsp_data,
  output logic                     tout_err
);

  localparam int CW = $clog2(TOUT + 1);

  state_t               state, state_n;
  logic [IDW-1:0]       ptr, ptr_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic                 done_q;
  logic                 done_rise;

  logic                 en_spi_n, busy_n, rsp_valid_n, tout_err_n;
  logic [DATABITS-1:0]  spi_tx_n, rsp_data_n;
  logic [SSW-1:0]       ss_n;
  logic [NREQ-1:0]      gnt_n;
  logic [IDW-1:0]       rsp_id_n;

  logic [NREQ-1:0]      arb_gnt;
  logic [IDW-1:0]       arb_idx;
  logic                 arb_found;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .found (arb_found)
  );

  // A level already high when WAIT is entered must not count as completion.
  assign done_rise = spi_done & ~done_q;

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    cnt_n       = cnt;
    en_spi_n    = 1'b0;
    spi_tx_n    = spi_tx;
    ss_n        = SS;
    gnt_n       = gnt;
    busy_n      = busy;
    rsp_valid_n = 1'b0;
    rsp_id_n    = rsp_id;
    rsp_data_n  = rsp_data;
    tout_err_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_found) begin
          gnt_n    = arb_gnt;
          ss_n     = req_ss[int'(arb_idx)*SSW +: SSW];
          spi_tx_n = req_cmd[int'(arb_idx)*DATABITS +: DATABITS];
          rsp_id_n = arb_idx;
          busy_n   = 1'b1;
          state_n  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        // Counter measures cycles since the start pulse, starting at it.
        en_spi_n = 1'b1;
        cnt_n    = '0;
        state_n  = ST_START;
      end
      ST_START: begin
        cnt_n   = cnt + 1'b1;
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion has priority over an expiry in the same cycle.
        if (done_rise) begin
          rsp_data_n  = spi_rx;
          rsp_valid_n = 1'b1;
          state_n     = ST_DONE;
        end else if (cnt >= CW'(TOUT - 1)) begin
          tout_err_n = 1'b1;
          state_n    = ST_DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_DONE: begin
        gnt_n   = '0;
        ss_n    = SS_IDLE[SSW-1:0];
        busy_n  = 1'b0;
        ptr_n   = (int'(rsp_id) == NREQ - 1) ? '0 : rsp_id + 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      cnt       <= '0;
      done_q    <= 1'b0;
      en_spi    <= 1'b0;
      spi_tx    <= '0;
      SS        <= SS_IDLE[SSW-1:0];
      gnt       <= '0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      tout_err  <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      done_q    <= spi_done;
      en_spi    <= en_spi_n;
      spi_tx    <= spi_tx_n;
      SS        <= ss_n;
      gnt       <= gnt_n;
      busy      <= busy_n;
      rsp_valid <= rsp_valid_n;
      rsp_id    <= rsp_id_n;
      rsp_data  <= rsp_data_n;
      tout_err  <= tout_err_n;
    end
  end

endmodule

// File: tb/tb_spi_req_scheduler.sv
// Self-checking bench for spi_req_scheduler: a scoreboard of expected
// completions is filled as slave responses are driven and drained by a
// monitor whenever rsp_valid or tout_err appears.
module tb_spi_req_scheduler;

  localparam int TOUT = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [23:0] req_cmd = {8'hC3, 8'h5A, 8'hA5};
  logic [5:0]  req_ss  = {2'b00, 2'b10, 2'b01};
  logic        spi_done = 1'b0;
  logic [7:0]  spi_rx = '0;
  logic        en_spi;
  logic [7:0]  spi_tx;
  logic [1:0]  SS;
  logic [2:0]  gnt;
  logic        busy;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        tout_err;

  spi_req_scheduler #(
    .NREQ(3), .DATABITS(8), .SSW(2), .TOUT(TOUT), .IDW(2)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd), .req_ss(req_ss),
    .spi_done(spi_done), .spi_rx(spi_rx), .en_spi(en_spi), .spi_tx(spi_tx),
    .SS(SS), .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .tout_err(tout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    bit         tout;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, en_cnt = 0, rsp_cnt = 0, tout_cnt = 0;
  int en_cyc = 0, tout_cyc = 0;
  bit auto_drop = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [7:0] data, input bit tout);
    exp_t x;
    x.id = id; x.data = data; x.tout = tout;
    sb.push_back(x);
  endtask

  function automatic logic [1:0] ss_of(input int id);
    return req_ss[id*2 +: 2];
  endfunction

  function automatic logic [7:0] cmd_of(input int id);
    return req_cmd[id*8 +: 8];
  endfunction

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (en_spi) begin
      en_cnt++;
      en_cyc = cyc;
    end
    if (rsp_valid || tout_err) begin
      if (rsp_valid) rsp_cnt++;
      if (tout_err) begin
        tout_cnt++;
        tout_cyc = cyc;
      end
      check_eq("sb_nonempty", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("rsp_id", 32'(rsp_id), 32'(e.id));
        check_eq("rsp_kind", {30'b0, rsp_valid, tout_err}, e.tout ? 32'd1 : 32'd2);
        if (!e.tout) check_eq("rsp_data", 32'(rsp_data), 32'(e.data));
      end
    end
  end

  // Requesters drop their line once they see their own completion.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (auto_drop && (rsp_valid || tout_err)) req = req & ~(3'b001 << rsp_id);
    end
  endtask

  task automatic wait_en(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      if (en_cnt >= target || (en_spi && en_cnt == target - 1)) ok = 1'b1;
      else tick(1);
    end
    check_eq("en_seen", 32'(ok), 1);
  endtask

  task automatic wait_rsp(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      tick(1);
      if (rsp_cnt + tout_cnt >= target) ok = 1'b1;
    end
    check_eq("rsp_seen", 32'(ok), 1);
  endtask

  task automatic serve(input int delay, input int hold, input logic [7:0] rx);
    int base;
    base = rsp_cnt + tout_cnt;
    tick(delay);
    spi_rx   = rx;
    spi_done = 1'b1;
    tick(hold);
    spi_done = 1'b0;
    if (rsp_cnt + tout_cnt <= base) wait_rsp(base + 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_base, r_base, t_base;

    // Reset values
    tick(3);
    check_eq("rst_en_spi", 32'(en_spi), 0);
    check_eq("rst_spi_tx", 32'(spi_tx), 0);
    check_eq("rst_ss", 32'(SS), 3);
    check_eq("rst_gnt", 32'(gnt), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
    check_eq("rst_rsp_id", 32'(rsp_id), 0);
    check_eq("rst_rsp_data", 32'(rsp_data), 0);
    check_eq("rst_tout_err", 32'(tout_err), 0);
    rst = 1'b0;
    tick(2);

    // Round-robin with all requests held: 0,1,2,0
    auto_drop = 1'b0;
    en_base = en_cnt;
    r_base  = rsp_cnt;
    req = 3'b111;
    for (int g = 0; g < 4; g++) begin
      int id;
      id = g % 3;
      wait_en(en_base + g + 1);
      check_eq("rr_gnt", 32'(gnt), 32'(3'b001 << id));
      check_eq("rr_ss", 32'(SS), 32'(ss_of(id)));
      check_eq("rr_tx", 32'(spi_tx), 32'(cmd_of(id)));
      push_exp(2'(id), 8'h10 + 8'(g), 1'b0);
      if (g == 3) begin
        req = 3'b001;
        auto_drop = 1'b1;
      end
      serve(2, (g == 1) ? 12 : 3, 8'h10 + 8'(g));
    end
    tick(4);
    check_eq("rr_en_count", 32'(en_cnt - en_base), 4);
    check_eq("rr_rsp_count", 32'(rsp_cnt - r_base), 4);
    check_eq("rr_idle_busy", 32'(busy), 0);

    // Single request (pointer at 1 wraps to requester 0)
    en_base = en_cnt;
    r_base  = rsp_cnt;
    req = 3'b001;
    wait_en(en_base + 1);
    check_eq("one_ss", 32'(SS), 32'(2'b01));
    check_eq("one_tx", 32'(spi_tx), 32'(8'hA5));
    check_eq("one_gnt", 32'(gnt), 1);
    check_eq("one_busy", 32'(busy), 1);
    push_exp(2'd0, 8'h3C, 1'b0);
    serve(6, 4, 8'h3C);
    tick(3);
    check_eq("one_en_count", 32'(en_cnt - en_base), 1);
    check_eq("one_rsp_count", 32'(rsp_cnt - r_base), 1);
    check_eq("one_ss_idle", 32'(SS), 3);
    check_eq("one_gnt_idle", 32'(gnt), 0);

    // Timeout on requester 1
    r_base = rsp_cnt;
    t_base = tout_cnt;
    req = 3'b010;
    wait_en(en_cnt + 1);
    push_exp(2'd1, 8'h00, 1'b1);
    wait_rsp(rsp_cnt + tout_cnt + 1);
    check_eq("tout_count", 32'(tout_cnt - t_base), 1);
    check_eq("tout_latency", 32'(tout_cyc - en_cyc), TOUT);
    check_eq("tout_no_rsp", 32'(rsp_cnt - r_base), 0);
    tick(2);

    // Next request served normally
    req = 3'b100;
    wait_en(en_cnt + 1);
    check_eq("after_tout_gnt", 32'(gnt), 32'(3'b100));
    push_exp(2'd2, 8'hE7, 1'b0);
    serve(3, 2, 8'hE7);
    tick(2);

    // Race: done rises on the expiry cycle
    t_base = tout_cnt;
    req = 3'b010;
    wait_en(en_cnt + 1);
    tick(TOUT - 1);
    push_exp(2'd1, 8'h5C, 1'b0);
    spi_rx   = 8'h5C;
    spi_done = 1'b1;
    wait_rsp(rsp_cnt + tout_cnt + 1);
    spi_done = 1'b0;
    check_eq("race_no_tout", 32'(tout_cnt - t_base), 0);
    tick(2);

    // Asynchronous reset in the middle of WAIT (pointer is 2 here)
    req = 3'b001;
    wait_en(en_cnt + 1);
    tick(3);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_en_spi", 32'(en_spi), 0);
    check_eq("arst_ss", 32'(SS), 3);
    check_eq("arst_gnt", 32'(gnt), 0);
    check_eq("arst_busy", 32'(busy), 0);
    check_eq("arst_spi_tx", 32'(spi_tx), 0);
    req = 3'b110;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_en(en_cnt + 1);
    check_eq("arst_first_gnt", 32'(gnt), 32'(3'b010));
    push_exp(2'd1, 8'h11, 1'b0);
    serve(3, 2, 8'h11);
    wait_en(en_cnt + 1);
    check_eq("arst_second_gnt", 32'(gnt), 32'(3'b100));
    push_exp(2'd2, 8'h22, 1'b0);
    serve(3, 2, 8'h22);
    tick(2);

    // Stale done level already high at START
    spi_rx   = 8'h77;
    spi_done = 1'b1;
    tick(2);
    r_base = rsp_cnt + tout_cnt;
    req = 3'b001;
    wait_en(en_cnt + 1);
    tick(5);
    check_eq("stale_none", 32'(rsp_cnt + tout_cnt - r_base), 0);
    spi_done = 1'b0;
    tick(2);
    push_exp(2'd0, 8'h99, 1'b0);
    spi_rx   = 8'h99;
    spi_done = 1'b1;
    wait_rsp(r_base + 1);
    spi_done = 1'b0;
    tick(4);

    check_eq("total_en", 32'(en_cnt), 12);
    check_eq("sb_drained", 32'(sb.size()), 0);
    check_eq("final_busy", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
